// File: rtl/miriscv_run_pkg.sv
// Shared types and constants for the miriscv run-control block.
package miriscv_run_pkg;

  typedef enum logic [1:0] {
    ST_HOLD = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } run_state_e;

  // Last word of the 512-word data RAM acts as the halt mailbox.
  localparam logic [31:0] TOHOST_ADDR_DEF = 32'h0000_07FC;
  localparam int unsigned PASS_CODE       = 1;

endpackage

// File: rtl/miriscv_sat_counter.sv
// Up-counter with enable, synchronous clear and saturation at all-ones.
module miriscv_sat_counter
  import miriscv_run_pkg::*;
#(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         clr,
  output logic [W-1:0] cnt,
  output logic         sat
);

  assign sat = &cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && !sat) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/miriscv_run_ctrl.sv
// Run control for miriscv_top: reset-hold sequence, cycle budget,
// tohost halt detection and idle watchdog, with sticky result flags.
module miriscv_run_ctrl
  import miriscv_run_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int CNT_W        = 32,
  parameter int RST_CYCLES   = 2,
  parameter int MAX_CYCLES   = 1000,
  parameter logic [ADDR_W-1:0] TOHOST_ADDR = ADDR_W'(TOHOST_ADDR_DEF),
  parameter int HALT_MODE    = 1,
  parameter int IDLE_LIMIT   = 256,
  parameter int HOLD_ON_DONE = 1
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              data_req_i,
  input  logic              data_we_i,
  input  logic [ADDR_W-1:0] data_addr_i,
  input  logic [DATA_W-1:0] data_wdata_i,
  output logic              core_rst_n_o,
  output logic              running_o,
  output logic              done_o,
  output logic              pass_o,
  output logic              timeout_o,
  output logic              hang_o,
  output logic [DATA_W-2:0] exit_code_o,
  output logic [CNT_W-1:0]  cycle_cnt_o
);

  run_state_e       st_q, st_d;
  logic             in_hold, in_run;
  logic             halt_hit, to_hit, hang_hit, finish;
  logic [CNT_W-1:0] hold_cnt, idle_cnt;
  logic             hold_sat, cyc_sat, idle_sat;
  logic             unused_sat;

  assign in_hold    = (st_q == ST_HOLD);
  assign in_run     = (st_q == ST_RUN);
  assign unused_sat = hold_sat ^ cyc_sat ^ idle_sat;

  miriscv_sat_counter #(.W(CNT_W)) u_hold_cnt (
    .clk   (clk_i),
    .rst_n (rst_n_i),
    .en    (in_hold),
    .clr   (!in_hold),
    .cnt   (hold_cnt),
    .sat   (hold_sat)
  );

  miriscv_sat_counter #(.W(CNT_W)) u_cycle_cnt (
    .clk   (clk_i),
    .rst_n (rst_n_i),
    .en    (in_run),
    .clr   (1'b0),
    .cnt   (cycle_cnt_o),
    .sat   (cyc_sat)
  );

  miriscv_sat_counter #(.W(CNT_W)) u_idle_cnt (
    .clk   (clk_i),
    .rst_n (rst_n_i),
    .en    (in_run && !data_req_i),
    .clr   (!in_run || data_req_i),
    .cnt   (idle_cnt),
    .sat   (idle_sat)
  );

  assign halt_hit = (HALT_MODE != 0) && data_req_i && data_we_i &&
                    (data_addr_i == TOHOST_ADDR) && (data_wdata_i != '0);
  assign to_hit   = (MAX_CYCLES != 0) && (cycle_cnt_o == CNT_W'(MAX_CYCLES - 1));
  assign hang_hit = (IDLE_LIMIT != 0) && !data_req_i &&
                    (idle_cnt == CNT_W'(IDLE_LIMIT - 1));

  always_comb begin
    st_d   = st_q;
    finish = 1'b0;
    case (st_q)
      ST_HOLD: if (hold_cnt == CNT_W'(RST_CYCLES - 1)) st_d = ST_RUN;
      ST_RUN: begin
        if (halt_hit || to_hit || hang_hit) begin
          st_d   = ST_DONE;
          finish = 1'b1;
        end
      end
      ST_DONE: st_d = ST_DONE;
      default: st_d = ST_HOLD;
    endcase
  end

  // Outputs are decoded from the next state so they change on the same
  // edge as the state register and never glitch.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      st_q         <= ST_HOLD;
      core_rst_n_o <= 1'b0;
      running_o    <= 1'b0;
      done_o       <= 1'b0;
      pass_o       <= 1'b0;
      timeout_o    <= 1'b0;
      hang_o       <= 1'b0;
      exit_code_o  <= '0;
    end else begin
      st_q         <= st_d;
      core_rst_n_o <= (st_d == ST_RUN) || ((st_d == ST_DONE) && (HOLD_ON_DONE == 0));
      running_o    <= (st_d == ST_RUN);
      done_o       <= (st_d == ST_DONE);
      if (finish) begin
        if (halt_hit) begin
          pass_o      <= (data_wdata_i == DATA_W'(PASS_CODE));
          exit_code_o <= data_wdata_i[DATA_W-1:1];
        end else if (to_hit) begin
          timeout_o <= 1'b1;
        end else begin
          hang_o <= 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/miriscv_run_ctrl.md
Name: miriscv_run_ctrl

Overview:
Synthesizable run-control and end-of-test detector that sits between the system reset and the miriscv_top core reset, and snoops the core data-memory bus. It replaces the fixed 1000-cycle run with the following:
- a parametrised reset-hold sequence;
- a cycle budget;
- halt detection through a "tohost" store;
- an idle watchdog.
It reports done, pass, timeout, hang and an exit code to the bench or board LEDs.

Parameters:
ADDR_W, 32, data bus address width
DATA_W, 32, data bus write-data width (>=8)
CNT_W, 32, cycle counter width
RST_CYCLES, 2, cycles core_rst_n_o held low after rst_n_i deasserts (>=1)
MAX_CYCLES, 1000, cycle budget in RUN; 0 disables timeout
TOHOST_ADDR, 32'h0000_07FC, word address of halt mailbox (last word of 512-word RAM)
HALT_MODE, 1, 0 = run until budget only; 1 = tohost store or budget
IDLE_LIMIT, 256, consecutive cycles with no data_req_i before hang; 0 disables
HOLD_ON_DONE, 1, 1 = re-assert core reset on entering DONE

Ports:
clk_i  in  1  system clock
rst_n_i  in  1  asynchronous active-low reset
data_req_i  in  1  core data request (snooped)
data_we_i  in  1  core data write enable
data_addr_i  in  ADDR_W  core data address
data_wdata_i  in  DATA_W  core write data
core_rst_n_o  out  1  active-low reset to miriscv_top
running_o  out  1  FSM in RUN
done_o  out  1  test finished (sticky)
pass_o  out  1  tohost value == 1
timeout_o  out  1  budget exhausted
hang_o  out  1  idle watchdog fired
exit_code_o  out  DATA_W-1  tohost value >> 1
cycle_cnt_o  out  CNT_W  cycles spent in RUN

Behaviour:
- Clocking and reset: one clock, clk_i. Reset is rst_n_i, asynchronous assert, active-low.
- While rst_n_i = 0, all outputs are 0, including core_rst_n_o. The state is HOLD and all counters are 0.
- HOLD state:
  - core_rst_n_o = 0.
  - The hold counter increments each cycle.
  - On the cycle the counter reaches RST_CYCLES-1, the next state is RUN.
  - core_rst_n_o goes to 1 on the first RUN cycle, registered with no glitch.
- RUN state: running_o = 1, core_rst_n_o = 1, cycle_cnt_o increments by 1 per cycle.
  - The counter saturates at all-ones and never wraps.
- Halt hit: data_req_i & data_we_i & (data_addr_i == TOHOST_ADDR) & (data_wdata_i != 0) & HALT_MODE == 1.
  - Next state is DONE.
  - pass_o = (wdata == 1).
  - exit_code_o = wdata[DATA_W-1:1].
  - A write of 0 to TOHOST is ignored.
- Timeout: when MAX_CYCLES != 0 and cycle_cnt_o == MAX_CYCLES-1 in RUN, the next state is DONE with timeout_o = 1.
- Idle watchdog:
  - The idle counter is cleared by any data_req_i and otherwise increments in RUN.
  - When IDLE_LIMIT != 0 and the counter reaches IDLE_LIMIT-1 without a request, the next state is DONE with hang_o = 1.
- Priority on simultaneous events in one cycle: halt hit > timeout > hang. Exactly one cause flag is ever set.
  - A halt hit with pass_o = 0 and no flag set means "fail with code".
- DONE state:
  - done_o = 1, running_o = 0.
  - cycle_cnt_o is frozen at the count including the terminating cycle.
  - All flags and exit_code_o are sticky until rst_n_i.
  - core_rst_n_o = 0 if HOLD_ON_DONE, else 1.
  - Bus activity in DONE is ignored.
- Reset mid-run: assertion of rst_n_i in any state returns to HOLD and clears everything immediately (asynchronous).
- All outputs are registered; there is no combinational path from data_* to outputs.
- Latency: a halt store sampled at edge N is visible on done_o after edge N.

Decomposition:
- Package miriscv_run_pkg holds:
  - the state encoding constants (ST_HOLD, ST_RUN, ST_DONE);
  - the default TOHOST_ADDR;
  - the pass code 1.
- One sub-module is natural: miriscv_sat_counter (parametrised width, enable, synchronous clear, saturate flag). It is instantiated three times: hold, cycle and idle counters.

Test Plan:
- Reset release with RST_CYCLES=2 -> core_rst_n_o low for exactly 2 clk_i edges after rst_n_i rises; running_o=1 on 3rd; cycle_cnt_o=0 on first RUN cycle.
- Store 32'h1 to 32'h07FC at RUN cycle 40 -> done_o=1, pass_o=1, exit_code_o=0, cycle_cnt_o=41, core_rst_n_o=0 next cycle; later stores do not change outputs.
- Store 32'h0000_0007 to TOHOST -> pass_o=0, exit_code_o=3; a prior store of 0 to TOHOST must not terminate.
- HALT_MODE=0 or no store, MAX_CYCLES=1000, data_req_i toggling every 10 cycles -> timeout_o=1, cycle_cnt_o=1000, pass_o=0; TOHOST store coincident with the last budget cycle -> pass_o=1, timeout_o=0.
- data_req_i held 0 with IDLE_LIMIT=16 -> hang_o=1 after 16 RUN cycles; a single request at cycle 15 restarts the count.
- rst_n_i pulsed low mid-RUN between clock edges -> all outputs 0 immediately, HOLD sequence restarts; same in DONE clears sticky flags.
